// File: rtl/log2_iter_pkg.sv
// rtl/log2_iter_pkg.sv - shared FSM encodings and width helpers for the iterative log2 unit
package log2_iter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_FRAC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int log_w_of(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // A zero-bit fraction port is not legal, so FRAC_BITS=0 still carries one bit.
    function automatic int frac_w_of(input int frac_bits);
        return (frac_bits > 0) ? frac_bits : 1;
    endfunction

endpackage

// File: rtl/log2_iter_if.sv
// rtl/log2_iter_if.sv - producer/consumer handshake bundle for log2_iter
interface log2_iter_if #(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 4
);
    import log2_iter_pkg::*;

    localparam int LOG_W  = log_w_of(WIDTH);
    localparam int FRAC_W = frac_w_of(FRAC_BITS);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  number;
    logic              out_valid;
    logic              out_ready;
    logic [LOG_W-1:0]  log_int;
    logic [FRAC_W-1:0] log_frac;
    logic              out_zero;

    modport slave (
        input  in_valid, number, out_ready,
        output in_ready, out_valid, log_int, log_frac, out_zero
    );

    modport master (
        output in_valid, number, out_ready,
        input  in_ready, out_valid, log_int, log_frac, out_zero
    );

endinterface

// File: rtl/log2_iter_lod.sv
// rtl/log2_iter_lod.sv - combinational leading-one detector, shared with the combinational log2
module lod
    import log2_iter_pkg::*;
#(
    parameter int   WIDTH = 8,
    localparam int  LOG_W = log_w_of(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [LOG_W-1:0] index,
    output logic             zero
);

    // Ascending scan: the last set bit seen wins, which is the highest one.
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                index = LOG_W'(i);
            end
        end
    end

    assign zero = ~|value;

endmodule

// File: rtl/log2_iter.sv
// rtl/log2_iter.sv - sequential log2: leading-one normalise, then one fractional bit per clock by squaring
module log2_iter
    import log2_iter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    log2_iter_if.slave  bus
);

    localparam int LOG_W  = log_w_of(WIDTH);
    localparam int FRAC_W = frac_w_of(FRAC_BITS);
    localparam int CNT_W  = $clog2(FRAC_BITS + 2);

    logic [1:0]          state;
    logic [WIDTH-1:0]    num_r;
    logic [WIDTH-1:0]    mant;
    logic [CNT_W-1:0]    cnt;
    logic [LOG_W-1:0]    log_int_r;
    logic [FRAC_W-1:0]   frac_r;
    logic                zero_r;
    logic                valid_r;

    logic [LOG_W-1:0]    lod_idx;
    logic                lod_zero;
    logic [LOG_W-1:0]    shamt;
    logic [WIDTH-1:0]    norm_mant;
    logic [2*WIDTH-1:0]  sq;
    logic                sq_ge2;
    logic                frac_bit;
    logic [WIDTH-1:0]    mant_next;
    logic [FRAC_W-1:0]   frac_next;

    lod #(.WIDTH(WIDTH)) u_lod (
        .value (num_r),
        .index (lod_idx),
        .zero  (lod_zero)
    );

    // Mantissa is 1.(WIDTH-1) fixed point, so its square is 2.(2*WIDTH-2) and never overflows.
    assign shamt     = LOG_W'(WIDTH - 1) - lod_idx;
    assign norm_mant = num_r << shamt;
    assign sq        = {{WIDTH{1'b0}}, mant} * {{WIDTH{1'b0}}, mant};
    assign sq_ge2    = sq[2*WIDTH-1];
    assign frac_bit  = sq_ge2 & ~zero_r;
    assign mant_next = sq_ge2 ? WIDTH'(sq >> WIDTH) : WIDTH'(sq >> (WIDTH - 1));
    assign frac_next = FRAC_W'({frac_r, frac_bit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            num_r     <= '0;
            mant      <= '0;
            cnt       <= '0;
            log_int_r <= '0;
            frac_r    <= '0;
            zero_r    <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        num_r  <= bus.number;
                        frac_r <= '0;
                        zero_r <= 1'b0;
                        state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    log_int_r <= lod_zero ? '0 : lod_idx;
                    zero_r    <= lod_zero;
                    mant      <= norm_mant;
                    cnt       <= '0;
                    state     <= (FRAC_BITS > 0) ? ST_FRAC : ST_DONE;
                end
                ST_FRAC: begin
                    mant   <= mant_next;
                    frac_r <= frac_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(FRAC_BITS - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle raises out_valid; results are then frozen until taken.
                    if (!valid_r) begin
                        valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = valid_r;
    assign bus.log_int   = log_int_r;
    assign bus.log_frac  = frac_r;
    assign bus.out_zero  = zero_r;

endmodule

// File: tb/tb_log2_iter.sv
// tb/tb_log2_iter.sv - directed self-checking bench for log2_iter (8-bit/4-frac and 16-bit/integer-only)
module tb_log2_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    log2_iter_if #(.WIDTH(8),  .FRAC_BITS(4)) b8 ();
    log2_iter_if #(.WIDTH(16), .FRAC_BITS(0)) b16 ();

    log2_iter #(.WIDTH(8), .FRAC_BITS(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    log2_iter #(.WIDTH(16), .FRAC_BITS(0)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent model: threshold compare on the real-valued square, not a bit pick.
    function automatic logic [31:0] ref_frac(input int w, input int fb, input logic [31:0] num);
        longint m, sq, two;
        int p;
        logic [31:0] f;
        f = 0;
        p = 0;
        for (int i = 0; i < w; i++) if (num[i]) p = i;
        if (num == 0) return 0;
        m   = longint'(num) << (w - 1 - p);
        two = longint'(2) << (2 * (w - 1));
        for (int i = 0; i < fb; i++) begin
            sq = m * m;
            if (sq >= two) begin
                f = (f << 1) | 1;
                m = sq >> w;
            end else begin
                f = f << 1;
                m = sq >> (w - 1);
            end
        end
        return f;
    endfunction

    task automatic send8(input logic [7:0] num, output int l);
        int g = 0;
        while (!b8.in_ready && g < 50) begin @(posedge clk); #1; g++; end
        b8.number   = num;
        b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        l = 0;
        while (!b8.out_valid && l < 50) begin @(posedge clk); #1; l++; end
    endtask

    task automatic send16(input logic [15:0] num, output int l);
        int g = 0;
        while (!b16.in_ready && g < 50) begin @(posedge clk); #1; g++; end
        b16.number   = num;
        b16.in_valid = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        l = 0;
        while (!b16.out_valid && l < 50) begin @(posedge clk); #1; l++; end
    endtask

    task automatic take8(input string tag, input logic [7:0] num, input int li, input logic [3:0] lf,
                         input logic z);
        send8(num, lat);
        check({tag, "_lat"},  lat, 6);
        check({tag, "_int"},  b8.log_int, li);
        check({tag, "_frac"}, b8.log_frac, lf);
        check({tag, "_zero"}, b8.out_zero, z);
        @(posedge clk); #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        b8.in_valid   = 1'b0;
        b8.number     = '0;
        b8.out_ready  = 1'b1;
        b16.in_valid  = 1'b0;
        b16.number    = '0;
        b16.out_ready = 1'b1;
        #1;
        check("rst_in_ready",  b8.in_ready, 1);
        check("rst_out_valid", b8.out_valid, 0);
        check("rst_log_int",   b8.log_int, 0);
        check("rst_log_frac",  b8.log_frac, 0);
        check("rst_out_zero",  b8.out_zero, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        take8("pow2_64", 8'b0100_0000, 6, 4'b0000, 1'b0);
        take8("n3",      8'd3,   1, 4'b1001, 1'b0);
        check("ref_n3", ref_frac(8, 4, 3), 4'b1001);
        take8("n255",    8'd255, 7, 4'b1111, 1'b0);
        check("ref_n255", ref_frac(8, 4, 255), 4'b1111);
        take8("n5",      8'd5,   2, 4'b0101, 1'b0);
        check("ref_n5", ref_frac(8, 4, 5), 4'b0101);
        take8("n1",      8'd1,   0, 4'b0000, 1'b0);
        take8("n0",      8'd0,   0, 4'b0000, 1'b1);

        // Backpressure: hold 5 cycles with a competing operand offered.
        b8.out_ready = 1'b0;
        send8(8'd3, lat);
        check("bp_lat", lat, 6);
        b8.number   = 8'h80;
        b8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid",    b8.out_valid, 1);
            check("bp_int",      b8.log_int, 1);
            check("bp_frac",     b8.log_frac, 4'b1001);
            check("bp_zero",     b8.out_zero, 0);
            check("bp_in_ready", b8.in_ready, 0);
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  b8.in_ready, 1);
        check("bp_release_out_valid", b8.out_valid, 0);

        // Reset during the third fractional iteration.
        b8.number   = 8'd200;
        b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  b8.in_ready, 1);
        check("mid_rst_out_valid", b8.out_valid, 0);
        check("mid_rst_log_int",   b8.log_int, 0);
        check("mid_rst_log_frac",  b8.log_frac, 0);
        check("mid_rst_out_zero",  b8.out_zero, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (b8.out_valid) seen++;
            end
            check("mid_rst_no_valid", seen, 0);
        end
        take8("after_rst_n2", 8'b0000_0010, 1, 4'b0000, 1'b0);

        // Integer-only 16-bit instance, back-to-back operands.
        send16(16'h8000, lat);
        check("w16_8000_lat",  lat, 2);
        check("w16_8000_int",  b16.log_int, 15);
        check("w16_8000_frac", b16.log_frac, 0);
        check("w16_8000_zero", b16.out_zero, 0);
        @(posedge clk); #1;
        send16(16'h0004, lat);
        check("w16_0004_lat",  lat, 2);
        check("w16_0004_int",  b16.log_int, 2);
        check("w16_0004_frac", b16.log_frac, 0);
        check("w16_0004_zero", b16.out_zero, 0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
